// File: rtl/record_pkg.sv
// Shared widths, default sizes and the status word for the record unit.
package record_pkg;

    localparam int DEF_WORD_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    // Index width that stays at least 1 bit for degenerate sizes.
    function automatic int clog2_safe(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    typedef struct packed {
        logic overflow;
        logic parityErr;
    } record_status_t;

endpackage

// File: rtl/record_fifo.sv
// Show-ahead FIFO: dout is the head entry, or the last popped word while empty; 0 latency.
// Push is refused only when full with no pop in the same cycle; pop is ignored when empty.
module record_fifo
    import record_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = clog2_safe(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [W-1:0]  last_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            if (do_push && !do_pop)      level <= level + LW'(1);
            else if (do_pop && !do_push) level <= level - LW'(1);
        end
    end

endmodule

// File: rtl/record_unit_fifo.sv
// Serial strobe/data recorder into a show-ahead FIFO; word valid 1 clk after final sample event.
// Consumer drains with dataValid/dataReady; full FIFO drops words (sticky overflow). Option: RECORD_PARITY_EN.
module record_unit_fifo
    import record_pkg::*;
#(
    parameter int WORD_W     = DEF_WORD_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int LSB_FIRST  = 1
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            enable,
    input  logic                            samplePulse,
    input  logic                            dIn,
    input  logic                            clearOvf,
    input  logic                            dataReady,
    output logic [WORD_W-1:0]               recordedOut,
    output logic                            dataValid,
    output logic                            overflow,
    output logic [$clog2(WORD_W+1)-1:0]     bitCount,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifoLevel,
    output logic                            parityErr
);

    localparam int CW = $clog2(WORD_W+1);

    logic              pulse_s1, pulse_s2, pulse_d;
    logic              din_s1, din_s2;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_shift;
    logic [WORD_W-1:0] push_word;
    logic              sample_ev;
    logic              last_bit;
    logic              push;
    logic              pop;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    record_status_t    status;

    assign sample_ev = enable & pulse_s2 & ~pulse_d;
    assign sr_shift  = (LSB_FIRST != 0) ? {din_s2, sr[WORD_W-1:1]} : {sr[WORD_W-2:0], din_s2};

`ifdef RECORD_PARITY_EN
    // The trailing parity bit is checked against the stored word, never shifted in.
    logic par_bad;
    assign last_bit  = (bitCount == CW'(WORD_W));
    assign push_word = sr;
    assign par_bad   = ^{sr, din_s2};
`else
    assign last_bit  = (bitCount == CW'(WORD_W-1));
    assign push_word = sr_shift;
`endif

    assign push      = sample_ev & last_bit;
    assign pop       = dataValid & dataReady;
    assign drop      = push & fifo_full & ~pop;
    assign dataValid = ~fifo_empty;
    assign overflow  = status.overflow;
    assign parityErr = status.parityErr;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pulse_s1 <= 1'b0;
            pulse_s2 <= 1'b0;
            pulse_d  <= 1'b0;
            din_s1   <= 1'b0;
            din_s2   <= 1'b0;
            sr       <= '0;
            bitCount <= '0;
            status   <= '0;
        end else begin
            pulse_s1 <= samplePulse;
            pulse_s2 <= pulse_s1;
            pulse_d  <= pulse_s2;
            din_s1   <= dIn;
            din_s2   <= din_s1;

            if (!enable) begin
                sr       <= '0;
                bitCount <= '0;
            end else if (sample_ev) begin
                if (last_bit) begin
                    sr       <= '0;
                    bitCount <= '0;
                end else begin
                    sr       <= sr_shift;
                    bitCount <= bitCount + CW'(1);
                end
            end

            if (drop)          status.overflow <= 1'b1;
            else if (clearOvf) status.overflow <= 1'b0;
`ifdef RECORD_PARITY_EN
            if (push && par_bad) status.parityErr <= 1'b1;
            else if (clearOvf)   status.parityErr <= 1'b0;
`endif
        end
    end

    record_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetN (resetN),
        .push   (push),
        .pop    (pop),
        .din    (push_word),
        .dout   (recordedOut),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifoLevel)
    );

endmodule
